// File: rtl/ad9363_spi_ctrl_pkg.sv
// AD9363 SPI controller shared types.
// Holds the FSM state, instruction field positions and the frame builder.
package ad9363_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int FRAME_W  = 24;
  localparam int RW_BIT   = 15;
  localparam int BC_MSB   = 14;
  localparam int BC_LSB   = 12;
  localparam int ADDR_MSB = 9;
  localparam int ADDR_LSB = 0;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic       wr,
    input logic [9:0] addr,
    input logic [7:0] wdata
  );
    logic [15:0] instr;
    instr = '0;
    instr[RW_BIT] = wr;
    instr[BC_MSB:BC_LSB] = 3'b000;
    instr[ADDR_MSB:ADDR_LSB] = addr;
    return {instr, wr ? wdata : 8'h00};
  endfunction

endpackage

// File: rtl/ad9363_spi_ctrl_if.sv
// Command / response handshake bundle of the AD9363 SPI controller.
// master drives commands and consumes responses; slave is the controller.
interface ad9363_spi_ctrl_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ad9363_spi_ctrl.sv
// AD9363 register-access SPI master: one 24-bit frame per command.
// Divider, bit counter, shift register and FSM share one clocked block.
module ad9363_spi_ctrl
  import ad9363_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ad9363_spi_ctrl_if.slave bus,
  output logic             spi_csn,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             busy
);

  if (CLK_DIV < 2) begin : g_div_chk
    $error("CLK_DIV must be at least 2");
  end

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [1:0]         rst_sync;
  logic               rst_i;
  state_t             state;
  logic [DW-1:0]      div_cnt;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame_nxt;
  logic [7:0]         rx;
  logic               wr_q;
  logic               rv_q;
  logic [7:0]         rd_q;
  logic               div_end;
  logic               cmd_ready;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i     = rst_sync[1];
  assign div_end   = (div_cnt == DIV_MAX);
  assign cmd_ready = (state == IDLE) && !rv_q;
  assign frame_nxt = build_frame(bus.cmd_write,
                                 bus.cmd_addr,
                                 bus.cmd_wdata);

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rd_q;
  assign spi_mosi      = shreg[FRAME_W-1];
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx       <= '0;
      wr_q     <= 1'b0;
      spi_csn  <= 1'b1;
      spi_sclk <= 1'b0;
      rv_q     <= 1'b0;
      rd_q     <= '0;
    end else begin
      if (rv_q && bus.rsp_ready) rv_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready) begin
            shreg   <= frame_nxt;
            wr_q    <= bus.cmd_write;
            rx      <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            spi_csn <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              // Only the data byte (periods 17..24) carries readback.
              if (bit_cnt >= 5'd16) rx <= {rx[6:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == 5'd23) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            div_cnt <= '0;
            spi_csn <= 1'b1;
            state   <= GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_end) begin
            div_cnt <= '0;
            rv_q    <= 1'b1;
            rd_q    <= wr_q ? 8'h00 : rx;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9363_spi_ctrl.sv
// Self-checking bench for ad9363_spi_ctrl with an AD9363 register model.
// Expectations are queued at command accept and retired at CSN rise / response.
module tb_ad9363_spi_ctrl;

  localparam int D   = 4;
  localparam int LAT = 51 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_csn, spi_sclk, spi_mosi, busy;
  logic spi_miso = 1'b0;

  ad9363_spi_ctrl_if bus ();

  ad9363_spi_ctrl #(.CLK_DIV(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .spi_csn  (spi_csn),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [23:0] exp_frame_q[$];
  logic [7:0]  exp_rsp_q[$];
  int          acc_q[$];

  // Device model: shifts MOSI on SCLK rise, drives MISO on SCLK fall.
  logic [7:0]  dev_mem [1024];
  logic [23:0] dev_sh = '0;
  int          dev_rise = 0;
  logic [7:0]  dev_byte = '0;

  always @(negedge spi_csn) begin
    dev_sh = '0;
    dev_rise = 0;
    dev_byte = '0;
    spi_miso = 1'b0;
  end

  always @(posedge spi_sclk) begin
    if (!spi_csn) begin
      dev_sh = {dev_sh[22:0], spi_mosi};
      dev_rise++;
      if (dev_rise == 16)
        dev_byte = dev_sh[15] ? 8'h00 : dev_mem[dev_sh[9:0]];
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_csn && dev_rise >= 16 && dev_rise < 24)
      spi_miso = dev_byte[23 - dev_rise];
  end

  always @(posedge spi_csn) begin
    if (rst_n) begin
      if (exp_frame_q.size() == 0) check("frame_unexpected", 1, 0);
      else check("mosi_frame", 32'(dev_sh), 32'(exp_frame_q.pop_front()));
      check("sclk_rises", dev_rise, 24);
      if (dev_sh[23] && dev_rise == 24) dev_mem[dev_sh[17:8]] = dev_sh[7:0];
    end
  end

  // Latency, response data and CSN gap monitors.
  logic rv_prev = 1'b0;
  int   csn_hi = 0;
  bit   seen_frame = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc + 1);
      if (bus.rsp_valid && !rv_prev) begin
        if (acc_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp_latency", cyc - acc_q.pop_front(), LAT);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_rsp_q.size() == 0) check("rsp_extra", 1, 0);
        else check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rsp_q.pop_front()));
      end
      if (spi_csn) begin
        csn_hi++;
      end else begin
        if (csn_hi > 0 && seen_frame) check("csn_gap_min", 32'(csn_hi >= D + 1), 1);
        csn_hi = 0;
        seen_frame = 1;
      end
    end else begin
      csn_hi = 0;
      seen_frame = 0;
    end
    rv_prev = bus.rsp_valid;
  end

  task automatic issue(input logic wr, input logic [9:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rd);
    bit done;
    done = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        check("no_accept_pending", 32'(bus.rsp_valid), 0);
        exp_frame_q.push_back({wr, 5'b00000, a, wr ? d : 8'h00});
        exp_rsp_q.push_back(wr ? 8'h00 : exp_rd);
        done = 1;
      end
    end
    if (!done) check("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = 8'($urandom);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_rsp_q.size() != 0) check("rsp_timeout", exp_rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen_rv;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) dev_mem[i] = 8'h00;
    dev_mem[10'h017] = 8'h1A;

    repeat (3) @(posedge clk);
    #1;
    check("rst_csn", 32'(spi_csn), 1);
    check("rst_sclk", 32'(spi_sclk), 0);
    check("rst_mosi", 32'(spi_mosi), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    issue(1'b1, 10'h037, 8'hA5, 8'h00);
    drain(1000);
    issue(1'b0, 10'h017, 8'hFF, 8'h1A);
    drain(1000);
    issue(1'b0, 10'h037, 8'h00, 8'hA5);
    drain(1000);

    // Response held back: nothing moves, new command waits.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 10'h017, 8'h00, 8'h1A);
    seen_rv = 0;
    for (int i = 0; i < 1000 && !seen_rv; i++) begin
      @(negedge clk);
      seen_rv = bus.rsp_valid;
    end
    check("holdoff_rsp_seen", 32'(seen_rv), 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 10'h155;
    bus.cmd_wdata = 8'h3C;
    repeat (50) begin
      @(negedge clk);
      check("holdoff_valid", 32'(bus.rsp_valid), 1);
      check("holdoff_rdata", 32'(bus.rsp_rdata), 32'h1A);
      check("holdoff_cmd_ready", 32'(bus.cmd_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 10'h155, 8'h3C, 8'h00);
    drain(1000);

    // Reset mid-frame aborts with no response.
    issue(1'b1, 10'h2AA, 8'h55, 8'h00);
    n = 0;
    while (dev_rise < 9 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_p10", 32'(dev_rise >= 9), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_csn", 32'(spi_csn), 1);
    check("abort_sclk", 32'(spi_sclk), 0);
    exp_frame_q.delete();
    exp_rsp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_rv = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rv = 1;
    end
    check("abort_no_rsp", 32'(seen_rv), 0);
    @(posedge clk);
    #1;
    issue(1'b1, 10'h2AA, 8'h55, 8'h00);
    drain(1000);
    issue(1'b0, 10'h2AA, 8'h00, 8'h55);
    drain(1000);

    // Back-to-back writes with rsp_ready tied high.
    for (int k = 0; k < 4; k++)
      issue(1'b1, 10'($urandom), 8'($urandom), 8'h00);
    drain(3000);

    check("scoreboard_empty",
          exp_frame_q.size() + exp_rsp_q.size() + acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9363_spi_ctrl.md
AD9363_SPI_CTRL -- requirements
Module: ad9363_spi_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; values below 2 SHALL be an elaboration error.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_write  input  1  1 = register write, 0 = register read.
REQ-007 SHALL have port cmd_addr  input  10  AD9363 register address.
REQ-008 SHALL have port cmd_wdata  input  8  write data; ignored on read.
REQ-009 SHALL have port rsp_valid  output  1  transaction complete.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-011 SHALL have port rsp_rdata  output  8  read data; 0 for writes.
REQ-012 SHALL have port spi_csn  output  1  chip select, active-low.
REQ-013 SHALL have port spi_sclk  output  1  SPI clock, idle low.
REQ-014 SHALL have port spi_mosi  output  1  serial data to device.
REQ-015 SHALL have port spi_miso  input  1  serial data from device.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL sequence states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-018 SHALL drive cmd_ready = (state == IDLE) and not rsp_valid, from registered state only.
REQ-019 On accept edge: SHALL latch a 24-bit frame {cmd_write, 3'b000, 2'b00, cmd_addr, cmd_wdata or 8'h00}, then enter SETUP with spi_csn low and spi_mosi = frame bit 23.
REQ-020 SETUP SHALL last CLK_DIV cycles with spi_sclk low.
REQ-021 SHIFT SHALL produce 24 SCLK periods; each period is CLK_DIV cycles low, then CLK_DIV cycles high; MSB first.
REQ-022 spi_mosi SHALL change only on SCLK falling edges, or at CSN fall for bit 23.
REQ-023 spi_miso SHALL be sampled on the clk edge that raises spi_sclk, for bits 7..0 (SCLK periods 17-24) only.
REQ-024 HOLD SHALL last CLK_DIV cycles with spi_sclk low and spi_csn low; spi_csn SHALL rise on exit.
REQ-025 GAP SHALL last CLK_DIV cycles with spi_csn high.
REQ-026 On GAP exit: rsp_valid SHALL assert, with rsp_rdata = captured byte (reads) or 8'h00 (writes); rsp_valid SHALL rise exactly 51*CLK_DIV clk edges after the accept edge.
REQ-027 rsp_valid and rsp_rdata SHALL hold stable until the rsp_ready handshake; rsp_valid SHALL clear on the next edge.
REQ-028 No new command SHALL be accepted while a response is pending.
REQ-029 cmd_valid deasserted mid-transaction SHALL have no effect; the latched frame completes.
REQ-030 spi_sclk SHALL be a register output free of glitches; spi_csn SHALL never toggle inside SHIFT.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, spi_csn 1, spi_sclk 0, spi_mosi 0, rsp_valid 0, rsp_rdata 0, busy 0; cmd_ready SHALL then be 1.
REQ-032 Reset during any transaction SHALL abort it: CSN high immediately, no response.
REQ-033 Reset release SHALL be synchronized inside the block, 2 flops, asserting asynchronously.

Structure
REQ-034 Package ad9363_pkg SHALL hold the state typedef, the instruction field constants (R/W bit 15, byte-count bits 14:12, address bits 9:0) and a frame-build function.
REQ-035 No sub-module is required: divider counter, bit counter (0-23), shift register and FSM SHALL sit in one module.

Verification
REQ-036 Write addr 0x037, data 0xA5, CLK_DIV=4: MOSI frame = 0x8037A5; rsp_valid at edge 204 after accept; rsp_rdata 0x00.
REQ-037 Read addr 0x017, device model returns 0x1A: frame = 0x001700; rsp_rdata 0x1A.
REQ-038 rsp_ready held low 50 cycles: rsp_valid and rsp_rdata stable; cmd_ready 0 throughout; a command offered meanwhile is accepted only after the handshake.
REQ-039 rst_n pulsed low at SCLK period 10: CSN high in the same cycle; no rsp_valid; the next write completes correctly.
REQ-040 Back-to-back writes with rsp_ready tied high: CSN high for at least CLK_DIV+1 cycles between frames; SCLK has exactly 24 rising edges per CSN-low window.
